// File: rtl/cbrt_pkg.sv
// Shared types and constants for the cube-root dispatch front-end.
//   X_W / ROOT_W / TAG_W : operand, root and tag widths
//   dispatch_state_t     : dispatcher FSM states
//   is_exact_cube()      : true when root^3 equals the operand
package cbrt_pkg;

  localparam int X_W    = 8;
  localparam int ROOT_W = 3;
  localparam int TAG_W  = 2;

  // Cycles WAIT_BUSY tolerates with busy low before declaring a fault.
  localparam int BUSY_WAIT_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    DELIVER
  } dispatch_state_t;

  // The root is zero-extended to X_W+1 bits so 7^3 = 343 fits without wrap.
  function automatic logic is_exact_cube(input logic [ROOT_W-1:0] root,
                                         input logic [X_W-1:0]    x);
    logic [X_W:0] r;
    logic [X_W:0] cube;
    r    = {{(X_W + 1 - ROOT_W){1'b0}}, root};
    cube = r * r * r;
    return cube == {1'b0, x};
  endfunction

endpackage

// File: rtl/cbrt_dispatch_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n          : clock, async active-low reset (clears pointers/count)
//   push, push_data     : write request and data (ignored when full)
//   pop, pop_data       : read request (ignored when empty), head data
//   full, empty, count  : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cbrt_dispatch.sv
// Operand front-end for the iterative cube-root unit.
// Buffers operands in a FIFO, launches them one at a time into the cbrt unit,
// and presents tagged results with an exact-cube flag.
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready/in_x/in_tag   : operand input (valid/ready)
//   cbrt_x/cbrt_start               : operand and launch pulse to cbrt unit
//   cbrt_busy/cbrt_result           : status and root from cbrt unit
//   out_valid/out_ready/out_root/out_tag/out_exact : result output
//   err                             : sticky fault (cbrt unit unresponsive)
//   pending                         : FIFO occupancy
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a queued operand; pops it on exit
// LAUNCH    | cbrt_start high for this single cycle
// WAIT_BUSY | waiting for the cbrt unit to acknowledge with busy
// WAIT_DONE | cbrt unit computing; capture result when busy drops
// DELIVER   | out_valid high, holding result until out_ready
module cbrt_dispatch
  import cbrt_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [X_W-1:0]             in_x,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [X_W-1:0]             cbrt_x,
  output logic                       cbrt_start,
  input  logic                       cbrt_busy,
  input  logic [ROOT_W-1:0]          cbrt_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROOT_W-1:0]          out_root,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_exact,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int FW = X_W + TAG_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  dispatch_state_t state;

  logic [FW-1:0]    fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [X_W-1:0]   head_x;
  logic [TAG_W-1:0] head_tag;

  logic [X_W-1:0]   x_q;
  logic [TAG_W-1:0] tag_q;
  logic [TW-1:0]    timer;

  assign in_ready = !fifo_full;
  assign fifo_pop = (state == IDLE) && !fifo_empty;
  assign head_x   = fifo_rdata[X_W-1:0];
  assign head_tag = fifo_rdata[FW-1:X_W];

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data ({in_tag, in_x}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  // Timers are down-counters: loaded with (cycles - 1) on entry, fault fires
  // on a cycle that sees terminal count zero without the awaited busy level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_q        <= '0;
      tag_q      <= '0;
      timer      <= '0;
      cbrt_x     <= '0;
      cbrt_start <= 1'b0;
      out_valid  <= 1'b0;
      out_root   <= '0;
      out_tag    <= '0;
      out_exact  <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            x_q        <= head_x;
            tag_q      <= head_tag;
            cbrt_x     <= head_x;
            cbrt_start <= 1'b1;
            state      <= LAUNCH;
          end
        end

        LAUNCH: begin
          cbrt_start <= 1'b0;
          timer      <= TW'(BUSY_WAIT_CYCLES - 1);
          state      <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (cbrt_busy) begin
            timer <= TW'(TIMEOUT - 1);
            state <= WAIT_DONE;
          end else if (timer == '0) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        WAIT_DONE: begin
          if (!cbrt_busy) begin
            out_root  <= cbrt_result;
            out_tag   <= tag_q;
            out_exact <= is_exact_cube(cbrt_result, x_q);
            out_valid <= 1'b1;
            state     <= DELIVER;
          end else if (timer == '0) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        DELIVER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbrt_dispatch.sv
module tb_cbrt_dispatch;
  import cbrt_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;
  localparam int PW      = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [X_W-1:0]    in_x;
  logic [TAG_W-1:0]  in_tag;
  logic [X_W-1:0]    cbrt_x;
  logic              cbrt_start;
  logic              cbrt_busy;
  logic [ROOT_W-1:0] cbrt_result;
  logic              out_valid;
  logic              out_ready;
  logic [ROOT_W-1:0] out_root;
  logic [TAG_W-1:0]  out_tag;
  logic              out_exact;
  logic              err;
  logic [PW-1:0]     pending;

  cbrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_tag      (in_tag),
    .cbrt_x      (cbrt_x),
    .cbrt_start  (cbrt_start),
    .cbrt_busy   (cbrt_busy),
    .cbrt_result (cbrt_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_root    (out_root),
    .out_tag     (out_tag),
    .out_exact   (out_exact),
    .err         (err),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, obs, exp, $time);
    end
  endtask

  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Behavioural cbrt unit: busy for a random latency after sampling start.
  bit stuck;
  int lat_min, lat_max;
  logic [X_W-1:0] cx;
  int ccnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbrt_busy   <= 1'b0;
      cbrt_result <= '0;
      ccnt        <= 0;
    end else if (cbrt_busy) begin
      if (ccnt <= 1) begin
        cbrt_busy   <= 1'b0;
        cbrt_result <= ROOT_W'(ref_root(int'(cx)));
      end else begin
        ccnt <= ccnt - 1;
      end
    end else if (cbrt_start && !stuck) begin
      cbrt_busy <= 1'b1;
      cx        <= cbrt_x;
      ccnt      <= int'($urandom_range(lat_max, lat_min));
    end
  end

  // Reference model: operands queued in order, one in flight, results in order.
  typedef struct { int x; int tag; } op_t;
  typedef struct { int root; int tag; int exact; } res_t;
  op_t  launch_q[$];
  res_t res_q[$];
  int   deliv_log[$];
  int   pushes, launches, delivered, starts_seen;
  int   cyc, fall_cyc, err_timer, last_push_edge, last_start_cyc;
  int   last_root, last_tag, last_exact;
  bit   err_exp, busy_prev, ov_prev, start_prev;

  initial begin
    cyc = 0; fall_cyc = -10; last_push_edge = 0; last_start_cyc = 0;
    pushes = 0; launches = 0; delivered = 0; starts_seen = 0; err_timer = 0;
    last_root = -1; last_tag = -1; last_exact = -1;
    err_exp = 0; busy_prev = 0; ov_prev = 0; start_prev = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_cbrt_start", cbrt_start, 0);
      check_eq("rst_cbrt_x", cbrt_x, 0);
      check_eq("rst_out_fields", {out_root, out_tag, out_exact}, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_pending", pending, 0);
      check_eq("rst_in_ready", in_ready, 1);
      launch_q.delete();
      res_q.delete();
      pushes = 0; launches = 0; err_timer = 0;
      err_exp = 0; busy_prev = 0; ov_prev = 0; start_prev = 0;
    end else begin
      if (err_timer != 0) begin
        err_timer--;
        if (err_timer == 0) begin
          err_exp = 1;
          if (res_q.size() > 0) res_q.delete(0);
        end
      end
      if (cbrt_start) begin
        check_eq("start_single_cycle", start_prev, 0);
        check_eq("start_has_operand", launch_q.size() > 0, 1);
        starts_seen++;
        launches++;
        last_start_cyc = cyc;
        if (launch_q.size() > 0) begin
          op_t o;
          res_t r;
          o = launch_q.pop_front();
          check_eq("cbrt_x", cbrt_x, o.x);
          r.root  = ref_root(o.x);
          r.tag   = o.tag;
          r.exact = (r.root * r.root * r.root == o.x);
          res_q.push_back(r);
        end
        if (stuck) err_timer = 3;
      end
      check_eq("pending", pending, pushes - launches);
      check_eq("in_ready", in_ready, (pushes - launches) < DEPTH);
      check_eq("err", err, err_exp);
      if (busy_prev && !cbrt_busy) fall_cyc = cyc;
      if (out_valid) begin
        check_eq("out_valid_has_result", res_q.size() > 0, 1);
        check_eq("no_start_in_deliver", cbrt_start, 0);
        if (!ov_prev) check_eq("out_valid_latency", cyc, fall_cyc + 1);
        if (res_q.size() > 0) begin
          check_eq("out_root", out_root, res_q[0].root);
          check_eq("out_tag", out_tag, res_q[0].tag);
          check_eq("out_exact", out_exact, res_q[0].exact);
          if (out_ready) begin
            last_root  = out_root;
            last_tag   = out_tag;
            last_exact = out_exact;
            deliv_log.push_back(int'(out_root));
            res_q.delete(0);
            delivered++;
          end
        end
      end
      if (in_valid && in_ready) begin
        op_t o;
        o.x   = int'(in_x);
        o.tag = int'(in_tag);
        launch_q.push_back(o);
        pushes++;
        last_push_edge = cyc + 1;
      end
      start_prev = cbrt_start;
      busy_prev  = cbrt_busy;
      ov_prev    = out_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_op(input int x, input int tag);
    bit ok = 0;
    in_x     = X_W'(x);
    in_tag   = TAG_W'(tag);
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    check_eq("push_accepted", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (launch_q.size() == 0 && res_q.size() == 0 && !out_valid &&
          err_timer == 0 && !cbrt_busy) begin
        ok = 1;
        break;
      end
    end
    check_eq("drain_done", ok, 1);
    @(posedge clk);
    #1;
  endtask

  bit rand_done;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[3];
    int roots[3];
    int exacts[3];
    int bp_x[5];
    int bp_root[5];
    int s0, d0;

    in_valid = 0; in_x = 0; in_tag = 0; out_ready = 0;
    stuck = 0; lat_min = 1; lat_max = 4;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Basic launch and timing: 27 -> root 3, exact.
    out_ready = 1;
    s0 = starts_seen;
    push_op(27, 1);
    wait_drain();
    check_eq("t1_launch_latency", last_start_cyc - last_push_edge, 1);
    check_eq("t1_start_count", starts_seen - s0, 1);
    check_eq("t1_root", last_root, 3);
    check_eq("t1_tag", last_tag, 1);
    check_eq("t1_exact", last_exact, 1);

    // Boundary operands.
    vals   = '{255, 0, 1};
    roots  = '{6, 0, 1};
    exacts = '{0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      push_op(vals[i], i);
      wait_drain();
      check_eq("t2_root", last_root, roots[i]);
      check_eq("t2_tag", last_tag, i);
      check_eq("t2_exact", last_exact, exacts[i]);
    end

    // Back-pressure: fill the FIFO behind a stalled result.
    bp_x    = '{8, 64, 125, 216, 1};
    bp_root = '{2, 4, 5, 6, 1};
    out_ready = 0;
    deliv_log.delete();
    for (int i = 0; i < 5; i++) push_op(bp_x[i], i % 4);
    check_eq("bp_pending_full", pending, 4);
    check_eq("bp_in_ready_low", in_ready, 0);
    s0 = starts_seen;
    step(10);
    check_eq("bp_hold_valid", out_valid, 1);
    check_eq("bp_hold_root", out_root, 2);
    check_eq("bp_hold_pending", pending, 4);
    check_eq("bp_no_start", starts_seen - s0, 0);
    out_ready = 1;
    wait_drain();
    check_eq("bp_count", deliv_log.size(), 5);
    for (int i = 0; i < 5 && i < deliv_log.size(); i++)
      check_eq("bp_order", deliv_log[i], bp_root[i]);

    // Randomised traffic with random consumer stalls and latencies.
    lat_min = 1; lat_max = 8;
    rand_done = 0;
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int x;
          if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 7)) ** 3 % 256;
          else x = int'($urandom_range(0, 255));
          push_op(x, int'($urandom_range(0, 3)));
          step(int'($urandom_range(0, 3)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1;
    wait_drain();
    check_eq("rand_delivered", delivered - d0, 40);

    // Unresponsive cbrt unit: fault after two busy-low cycles, then recover.
    lat_min = 1; lat_max = 4;
    stuck = 1;
    d0 = delivered;
    push_op(8, 2);
    wait_drain();
    check_eq("fault_err", err, 1);
    check_eq("fault_no_result", delivered - d0, 0);
    check_eq("fault_pending", pending, 0);
    stuck = 0;
    push_op(27, 3);
    wait_drain();
    check_eq("fault_recover_root", last_root, 3);
    check_eq("fault_err_sticky", err, 1);

    // Reset while in WAIT_DONE with three operands queued.
    lat_min = 30; lat_max = 30;
    for (int i = 0; i < 4; i++) push_op(64 + i, i);
    step(2);
    check_eq("mid_pending", pending, 3);
    check_eq("mid_busy", cbrt_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_pending", pending, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_err", err, 0);
    step(2);
    rst_n = 1'b1;
    s0 = starts_seen;
    d0 = delivered;
    step(40);
    check_eq("post_rst_no_start", starts_seen - s0, 0);
    check_eq("post_rst_no_result", delivered - d0, 0);
    check_eq("post_rst_out_valid", out_valid, 0);

    lat_min = 1; lat_max = 4;
    push_op(125, 2);
    wait_drain();
    check_eq("post_rst_root", last_root, 5);
    check_eq("post_rst_exact", last_exact, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
